// File: rtl/ray_dispatcher.sv
// Raster-order pixel dispatcher for a pool of ray units, with a one-write-per-cycle result arbiter.
// Optional macro DISPATCH_PERF_EN adds frame_cycles_out, the busy-cycle count of the last frame.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_dispatcher #(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int unsigned H_BITS         = `H_BITS,
    parameter int unsigned V_BITS         = `V_BITS,
    parameter int unsigned ADDR_BITS      = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [NUM_UNITS-1:0]        unit_ready_in,
    input  logic [NUM_UNITS*H_BITS-1:0] unit_hcount_in,
    input  logic [NUM_UNITS*V_BITS-1:0] unit_vcount_in,
    input  logic [NUM_UNITS*4-1:0]      unit_color_in,
    output logic [NUM_UNITS-1:0]        unit_valid_out,
    output logic [H_BITS-1:0]           hcount_out,
    output logic [V_BITS-1:0]           vcount_out,
    output logic                        fb_we_out,
    output logic [ADDR_BITS-1:0]        fb_addr_out,
    output logic [3:0]                  fb_data_out,
    output logic                        busy_out,
    output logic                        frame_done_out
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]                 frame_cycles_out
`endif
);

    localparam int unsigned       CNT_BITS = $clog2(NUM_UNITS + 1);
    localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(DISPLAY_HEIGHT - 1);
    localparam logic [31:0]       WIDTH_32 = 32'(DISPLAY_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN} state_t;
    typedef enum logic [1:0] {U_IDLE, U_LAUNCHED, U_BUSY, U_PENDING} ustate_t;

    state_t                state, state_nx;
    ustate_t               ustate    [NUM_UNITS];
    ustate_t               ustate_nx [NUM_UNITS];
    logic [H_BITS-1:0]     h_cnt, h_nx;
    logic [V_BITS-1:0]     v_cnt, v_nx;
    logic [CNT_BITS-1:0]   outstanding, out_nx;
    logic [NUM_UNITS-1:0]  valid_nx;
    logic [H_BITS-1:0]     hc_nx;
    logic [V_BITS-1:0]     vc_nx;
    logic                  we_nx;
    logic [ADDR_BITS-1:0]  addr_nx;
    logic [3:0]            data_nx;
    logic                  busy_nx;
    logic                  done_nx;

    logic                  launch;
    logic                  write;
    int                    launch_idx;
    int                    write_idx;
    logic [H_BITS-1:0]     wr_h;
    logic [V_BITS-1:0]     wr_v;
    logic [3:0]            wr_color;
    logic [31:0]           addr_full;

    // State and all outputs are registered here; next values come from the block below.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= S_IDLE;
            h_cnt          <= '0;
            v_cnt          <= '0;
            outstanding    <= '0;
            unit_valid_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            fb_we_out      <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= '0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
            for (int i = 0; i < int'(NUM_UNITS); i++) ustate[i] <= U_IDLE;
        end else begin
            state          <= state_nx;
            h_cnt          <= h_nx;
            v_cnt          <= v_nx;
            outstanding    <= out_nx;
            unit_valid_out <= valid_nx;
            hcount_out     <= hc_nx;
            vcount_out     <= vc_nx;
            fb_we_out      <= we_nx;
            fb_addr_out    <= addr_nx;
            fb_data_out    <= data_nx;
            busy_out       <= busy_nx;
            frame_done_out <= done_nx;
            for (int i = 0; i < int'(NUM_UNITS); i++) ustate[i] <= ustate_nx[i];
        end
    end

    always_comb begin
        state_nx   = state;
        h_nx       = h_cnt;
        v_nx       = v_cnt;
        out_nx     = outstanding;
        valid_nx   = '0;
        hc_nx      = hcount_out;
        vc_nx      = vcount_out;
        we_nx      = 1'b0;
        addr_nx    = fb_addr_out;
        data_nx    = fb_data_out;
        done_nx    = 1'b0;
        busy_nx    = 1'b0;
        launch     = 1'b0;
        write      = 1'b0;
        launch_idx = 0;
        write_idx  = 0;
        wr_h       = '0;
        wr_v       = '0;
        wr_color   = '0;
        addr_full  = '0;

        // Descending scan so the lowest eligible / pending index wins.
        for (int i = int'(NUM_UNITS) - 1; i >= 0; i--) begin
            if (ustate[i] == U_IDLE && unit_ready_in[i]) begin
                launch     = 1'b1;
                launch_idx = i;
            end
            if (ustate[i] == U_PENDING) begin
                write     = 1'b1;
                write_idx = i;
            end
        end
        launch = launch && (state == S_DISPATCH);

        // LAUNCHED waits for ready to drop, absorbing the unit's registered-ready lag.
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            ustate_nx[i] = ustate[i];
            case (ustate[i])
                U_LAUNCHED: if (!unit_ready_in[i]) ustate_nx[i] = U_BUSY;
                U_BUSY:     if (unit_ready_in[i])  ustate_nx[i] = U_PENDING;
                default:    ;
            endcase
            if (write && i == write_idx) begin
                wr_h         = unit_hcount_in[i*H_BITS +: H_BITS];
                wr_v         = unit_vcount_in[i*V_BITS +: V_BITS];
                wr_color     = unit_color_in[i*4 +: 4];
                ustate_nx[i] = U_IDLE;
            end
            if (launch && i == launch_idx) begin
                valid_nx[i]  = 1'b1;
                ustate_nx[i] = U_LAUNCHED;
            end
        end

        if (write) begin
            we_nx     = 1'b1;
            addr_full = 32'(wr_v) * WIDTH_32 + 32'(wr_h);
            addr_nx   = ADDR_BITS'(addr_full);
            data_nx   = wr_color;
        end
        if (launch) begin
            hc_nx = h_cnt;
            vc_nx = v_cnt;
        end

        case (state)
            S_IDLE: begin
                if (start_in) begin
                    state_nx = S_DISPATCH;
                    h_nx     = '0;
                    v_nx     = '0;
                end
            end
            S_DISPATCH: begin
                if (launch) begin
                    if (h_cnt == H_LAST) begin
                        h_nx = '0;
                        if (v_cnt == V_LAST) begin
                            v_nx     = '0;
                            state_nx = S_DRAIN;
                        end else begin
                            v_nx = v_cnt + 1'b1;
                        end
                    end else begin
                        h_nx = h_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (outstanding == '0) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (state == S_IDLE && start_in) out_nx = '0;
        else out_nx = outstanding + CNT_BITS'(launch) - CNT_BITS'(write);
        busy_nx = (state_nx != S_IDLE);
    end

`ifdef DISPATCH_PERF_EN
    logic [31:0] cycle_cnt;

    // Counts busy cycles of the current frame; published when frame_done_out pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt        <= '0;
            frame_cycles_out <= '0;
        end else begin
            if (state == S_IDLE && start_in) cycle_cnt <= '0;
            else if (busy_out && cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
            if (frame_done_out) frame_cycles_out <= cycle_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Scoreboard bench for ray_dispatcher: 2 behavioural ray units on a 4x2 display,
// plus a 1-unit 2x1 instance exercising frame_cycles_out when DISPATCH_PERF_EN is defined.
`timescale 1ns/1ps
module tb_ray_dispatcher;
    localparam int NU = 2, W = 4, H = 2, HB = 2, VB = 1, AB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [NU-1:0]    unit_ready, unit_valid;
    logic [NU-1:0]    ready_en = 2'b11;
    logic [NU*HB-1:0] unit_h;
    logic [NU*VB-1:0] unit_v;
    logic [NU*4-1:0]  unit_c;
    logic [HB-1:0]    hcount;
    logic [VB-1:0]    vcount;
    logic             fb_we, busy, done;
    logic [AB-1:0]    fb_addr;
    logic [3:0]       fb_data;
`ifdef DISPATCH_PERF_EN
    logic [31:0]      frame_cycles;
`endif

    ray_dispatcher #(.NUM_UNITS(NU), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
                     .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .unit_ready_in(unit_ready), .unit_hcount_in(unit_h), .unit_vcount_in(unit_v),
        .unit_color_in(unit_c), .unit_valid_out(unit_valid), .hcount_out(hcount),
        .vcount_out(vcount), .fb_we_out(fb_we), .fb_addr_out(fb_addr), .fb_data_out(fb_data),
        .busy_out(busy), .frame_done_out(done)
`ifdef DISPATCH_PERF_EN
        , .frame_cycles_out(frame_cycles)
`endif
    );

    int errors = 0, checks = 0, cyc = 0;
    int lat [NU];
    int color_mode = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] color_of(int h, int v);
        if (color_mode == 1) return (h % 2 == 1) ? 4'h5 : 4'hA;
        return 4'((h * 3 + v * 5 + 1) % 16);
    endfunction

    // Behavioural ray units: ready drops after accepting a pixel, rises lat cycles later.
    logic             m_ready [NU];
    int               m_cnt   [NU];
    logic [HB-1:0]    m_h     [NU];
    logic [VB-1:0]    m_v     [NU];
    logic [3:0]       m_col   [NU];
    always @(posedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (rst) begin
                m_ready[i] <= 1'b1; m_cnt[i] <= 0; m_h[i] <= '0; m_v[i] <= '0; m_col[i] <= '0;
            end else if (m_ready[i] && unit_valid[i]) begin
                m_ready[i] <= 1'b0; m_cnt[i] <= lat[i] - 1;
                m_h[i] <= hcount; m_v[i] <= vcount; m_col[i] <= color_of(int'(hcount), int'(vcount));
            end else if (!m_ready[i]) begin
                if (m_cnt[i] == 0) m_ready[i] <= 1'b1;
                else m_cnt[i] <= m_cnt[i] - 1;
            end
        end
    end
    assign unit_ready = {m_ready[1], m_ready[0]} & ready_en;
    assign unit_h     = {m_h[1], m_h[0]};
    assign unit_v     = {m_v[1], m_v[0]};
    assign unit_c     = {m_col[1], m_col[0]};

    // Scoreboard: expected write pushed on each launch, popped when the DUT writes.
    typedef struct { int addr; logic [3:0] data; } wr_t;
    wr_t  exp_q[$];
    int   unit_q[$];
    int   pend [NU];
    int   wlog_cyc[$];
    logic [3:0] wlog_data[$];
    int   exp_h, exp_v, launches, writes, done_cnt, busy_cyc;
    logic [NU-1:0] valid_or;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        int  idx;
        wr_t e;
        if (mon_en) begin
            if (unit_valid != '0) begin
                idx = 0;
                for (int i = NU - 1; i >= 0; i--) if (unit_valid[i]) idx = i;
                valid_or = valid_or | unit_valid;
                checks++;
                if ($countones(unit_valid) != 1) begin
                    errors++; $display("FAIL onehot: unit_valid=%b required exactly one bit", unit_valid);
                end
                checks++;
                if (launches >= W * H) begin
                    errors++; $display("FAIL extra_launch: launch #%0d, required at most %0d", launches + 1, W * H);
                end else if (int'(hcount) != exp_h || int'(vcount) != exp_v) begin
                    errors++; $display("FAIL launch_order: got (%0d,%0d) required (%0d,%0d)", hcount, vcount, exp_h, exp_v);
                end
                checks++;
                if (pend[idx] != 0) begin
                    errors++; $display("FAIL relaunch: unit %0d launched with %0d unwritten results, required 0", idx, pend[idx]);
                end
                pend[idx]++;
                unit_q.push_back(idx);
                exp_q.push_back('{exp_v * W + exp_h, color_of(exp_h, exp_v)});
                launches++;
                if (exp_h == W - 1) begin exp_h = 0; exp_v = (exp_v + 1) % H; end
                else exp_h++;
            end
            if (fb_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_write: addr=%0d data=%h, required no write", fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    if (fb_addr !== AB'(e.addr) || fb_data !== e.data) begin
                        errors++; $display("FAIL fb_write: got addr=%0d data=%h required addr=%0d data=%h", fb_addr, fb_data, e.addr, e.data);
                    end
                end
                if (unit_q.size() != 0) begin idx = unit_q.pop_front(); pend[idx]--; end
                wlog_cyc.push_back(cyc);
                wlog_data.push_back(fb_data);
                writes++;
            end
            if (done) done_cnt++;
            if (busy) busy_cyc++;
        end
    end

    task automatic clear_sb();
        exp_q.delete(); unit_q.delete(); wlog_cyc.delete(); wlog_data.delete();
        for (int i = 0; i < NU; i++) pend[i] = 0;
        exp_h = 0; exp_v = 0; launches = 0; writes = 0; done_cnt = 0; busy_cyc = 0; valid_or = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
        ok = (done_cnt != d0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({unit_valid, hcount, vcount, fb_we, fb_addr, fb_data, busy, done} !== '0) begin
            errors++; $display("FAIL reset_outputs: valid=%b h=%0d v=%0d we=%b addr=%0d data=%h busy=%b done=%b, required all 0",
                               unit_valid, hcount, vcount, fb_we, fb_addr, fb_data, busy, done);
        end
`ifdef DISPATCH_PERF_EN
        checks++;
        if (frame_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_frame_cycles: got %0d required 0", frame_cycles);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
    endtask

    task automatic test_full_frame();
        bit ok;
        lat[0] = 5; lat[1] = 5; color_mode = 0; ready_en = 2'b11;
        clear_sb(); mon_en = 1'b1;
        pulse_start();
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_frame_timeout: no frame_done within budget"); end
        checks++; if (launches != W * H) begin errors++; $display("FAIL full_frame_launches: got %0d required %0d", launches, W * H); end
        checks++; if (writes != W * H || exp_q.size() != 0) begin
            errors++; $display("FAIL full_frame_writes: got %0d writes, %0d unwritten, required %0d and 0", writes, exp_q.size(), W * H);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_frame_done: got %0d done cycles required 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_frame_busy: busy=%b required 0", busy); end
`ifdef DISPATCH_PERF_EN
        checks++; if (frame_cycles !== 32'(busy_cyc)) begin
            errors++; $display("FAIL full_frame_cycles: got %0d required %0d", frame_cycles, busy_cyc);
        end
`endif
    endtask

    task automatic test_simultaneous();
        bit ok;
        lat[0] = 6; lat[1] = 5; color_mode = 1; ready_en = 2'b11;
        clear_sb(); mon_en = 1'b1;
        pulse_start();
        wait_done(400, ok);
        checks++; if (!ok || writes != W * H) begin
            errors++; $display("FAIL simul_frame: done=%b writes=%0d required 1 and %0d", ok, writes, W * H);
        end
        checks++;
        if (wlog_data.size() < 2) begin
            errors++; $display("FAIL simul_order: got %0d writes required at least 2", wlog_data.size());
        end else if (wlog_data[0] !== 4'hA || wlog_data[1] !== 4'h5 || wlog_cyc[1] != wlog_cyc[0] + 1) begin
            errors++; $display("FAIL simul_order: got %h@%0d %h@%0d required A then 5 on consecutive cycles",
                               wlog_data[0], wlog_cyc[0], wlog_data[1], wlog_cyc[1]);
        end
        color_mode = 0;
    endtask

    task automatic test_unit0_stalled();
        bit ok;
        lat[0] = 5; lat[1] = 5; ready_en = 2'b10;
        clear_sb(); mon_en = 1'b1;
        pulse_start();
        wait_done(600, ok);
        checks++; if (!ok || writes != W * H) begin
            errors++; $display("FAIL stall_frame: done=%b writes=%0d required 1 and %0d", ok, writes, W * H);
        end
        checks++; if (valid_or !== 2'b10) begin
            errors++; $display("FAIL stall_units: units launched=%b required 10", valid_or);
        end
        ready_en = 2'b11;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int n = 0;
        clear_sb(); mon_en = 1'b1;
        pulse_start();
        while (launches < 5 && n < 200) begin @(posedge clk); n++; end
        checks++; if (launches < 5) begin errors++; $display("FAIL restart_setup: got %0d launches required 5", launches); end
        pulse_start();
        wait_done(400, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok || done_cnt != 1) begin
            errors++; $display("FAIL restart_done: done=%b count=%0d required 1 and 1", ok, done_cnt);
        end
        checks++; if (launches != W * H || writes != W * H || busy !== 1'b0) begin
            errors++; $display("FAIL restart_frame: launches=%0d writes=%0d busy=%b required %0d %0d 0", launches, writes, busy, W * H, W * H);
        end
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        int n = 0;
        clear_sb(); mon_en = 1'b1;
        pulse_start();
        while (!(launches == W * H && launches - writes == 2) && n < 400) begin @(posedge clk); n++; end
        checks++; if (!(launches == W * H && launches - writes == 2)) begin
            errors++; $display("FAIL drain_setup: launches=%0d writes=%0d required %0d with 2 outstanding", launches, writes, W * H);
        end
        @(negedge clk); mon_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({unit_valid, hcount, vcount, fb_we, fb_addr, fb_data, busy, done} !== '0) begin
            errors++; $display("FAIL drain_reset: valid=%b h=%0d v=%0d we=%b addr=%0d data=%h busy=%b done=%b, required all 0",
                               unit_valid, hcount, vcount, fb_we, fb_addr, fb_data, busy, done);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || fb_we !== 1'b0) begin
            errors++; $display("FAIL drain_idle: busy=%b we=%b required 0 0", busy, fb_we);
        end
        clear_sb(); mon_en = 1'b1;
        pulse_start();
        wait_done(400, ok);
        checks++; if (!ok || writes != W * H || exp_q.size() != 0 || done_cnt != 1) begin
            errors++; $display("FAIL post_reset_frame: done=%b writes=%0d left=%0d dones=%0d required 1 %0d 0 1",
                               ok, writes, exp_q.size(), done_cnt, W * H);
        end
        mon_en = 1'b0;
    endtask

`ifdef DISPATCH_PERF_EN
    logic        p_start = 1'b0;
    logic        p_ready_r, p_valid, p_h, p_v, p_we, p_addr, p_busy, p_done, pm_h;
    logic [3:0]  p_data, pm_col;
    logic [31:0] p_cycles;
    int          p_cnt, p_busy_cyc, p_done_cnt, p_writes;

    ray_dispatcher #(.NUM_UNITS(1), .DISPLAY_WIDTH(2), .DISPLAY_HEIGHT(1),
                     .H_BITS(1), .V_BITS(1), .ADDR_BITS(1)) pdut (
        .clk_in(clk), .rst_in(rst), .start_in(p_start),
        .unit_ready_in(p_ready_r), .unit_hcount_in(pm_h), .unit_vcount_in(1'b0),
        .unit_color_in(pm_col), .unit_valid_out(p_valid), .hcount_out(p_h),
        .vcount_out(p_v), .fb_we_out(p_we), .fb_addr_out(p_addr), .fb_data_out(p_data),
        .busy_out(p_busy), .frame_done_out(p_done), .frame_cycles_out(p_cycles)
    );

    always @(posedge clk) begin
        if (rst) begin
            p_ready_r <= 1'b1; p_cnt <= 0; pm_h <= 1'b0; pm_col <= 4'h0;
        end else if (p_ready_r && p_valid) begin
            p_ready_r <= 1'b0; p_cnt <= 2; pm_h <= p_h; pm_col <= color_of(int'(p_h), int'(p_v));
        end else if (!p_ready_r) begin
            if (p_cnt == 0) p_ready_r <= 1'b1;
            else p_cnt <= p_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (p_busy) p_busy_cyc++;
        if (p_done) p_done_cnt++;
        if (p_we) begin
            checks++;
            if (p_addr !== 1'(p_writes) || p_data !== color_of(p_writes, 0)) begin
                errors++; $display("FAIL perf_write: got addr=%0d data=%h required addr=%0d data=%h",
                                   p_addr, p_data, p_writes, color_of(p_writes, 0));
            end
            p_writes++;
        end
    end

    task automatic test_perf();
        int n = 0;
        p_busy_cyc = 0; p_done_cnt = 0; p_writes = 0;
        @(negedge clk); p_start = 1'b1;
        @(negedge clk); p_start = 1'b0;
        while (p_done_cnt == 0 && n < 200) begin @(posedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++; if (p_done_cnt != 1 || p_writes != 2) begin
            errors++; $display("FAIL perf_frame: dones=%0d writes=%0d required 1 and 2", p_done_cnt, p_writes);
        end
        checks++; if (p_busy_cyc == 0 || p_cycles !== 32'(p_busy_cyc)) begin
            errors++; $display("FAIL perf_cycles: got %0d required %0d (nonzero)", p_cycles, p_busy_cyc);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        lat[0] = 5; lat[1] = 5;
        clear_sb();
        test_reset();
        test_full_frame();
        test_simultaneous();
        test_unit0_stalled();
        test_start_ignored();
        test_reset_in_drain();
`ifdef DISPATCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
